load_store_unit: RTL and testbench

Execute/memory-stage load/store unit for the RISC-V core. It takes the effective address computed by the ALU, plus the store data and the funct3 field. It runs one data-memory bus transaction with a req/ack handshake: byte strobes and lane replication on stores, lane extraction and sign/zero extension on loads. It returns a writeback result or a fault to the pipeline, and stalls the pipeline while the transaction is outstanding.

---
 rtl/load_store_unit.sv | 201 ++++++++++++++++++++
 tb/tb_load_store_unit.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/load_store_unit.sv
// load_store_unit: one data-memory transaction per accepted load/store,
//   with store lane steering, load extraction/extension and fault reporting.
// Latency: accept -> dmem_req next cycle; ack at edge k -> resp_valid in cycle k+1;
//   a fault pulses fault_valid one cycle after accept with no bus activity.
// Backpressure: req_ready only in IDLE; dmem_req is held until dmem_ack.
// Ports: clk/rst; req_* execute-stage request; dmem_* bus side;
//   resp_* writeback pulse; fault_* fault pulse and held address; busy stall.
module load_store_unit #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              is_store,
    input  logic [2:0]        funct3,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [4:0]        rd_in,
    output logic              dmem_req,
    output logic              dmem_wen,
    output logic [ADDR_W-1:0] dmem_addr,
    output logic [DATA_W-1:0] dmem_wdata,
    output logic [3:0]        dmem_strobe,
    input  logic [DATA_W-1:0] dmem_rdata,
    input  logic              dmem_ack,
    output logic              resp_valid,
    output logic [DATA_W-1:0] resp_data,
    output logic [4:0]        resp_rd,
    output logic              fault_valid,
    output logic              fault_cause,
    output logic [ADDR_W-1:0] fault_addr,
    output logic              busy
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_BUS   = 2'd1,
        S_RESP  = 2'd2,
        S_FAULT = 2'd3
    } state_t;

    state_t              state_q, state_d;
    logic                is_store_q, is_store_d;
    logic [2:0]          funct3_q, funct3_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic [4:0]          rd_q, rd_d;
    logic [DATA_W-1:0]   resp_data_q, resp_data_d;
    logic [4:0]          resp_rd_q, resp_rd_d;
    logic                fault_cause_q, fault_cause_d;
    logic [ADDR_W-1:0]   fault_addr_q, fault_addr_d;

    // Decode of the incoming op, used only at accept time.
    logic illegal_in;
    logic misaligned_in;

    always_comb begin
        if (is_store) begin
            illegal_in = (funct3 > 3'd2);
        end else begin
            illegal_in = (funct3 == 3'd3) || (funct3 == 3'd6) || (funct3 == 3'd7);
        end
        misaligned_in = ((funct3[1:0] == 2'd1) && addr[0]) ||
                        ((funct3[1:0] == 2'd2) && (addr[1:0] != 2'b00));
    end

    // Store lane steering from the registered op.
    logic [3:0]        st_strobe;
    logic [DATA_W-1:0] st_wdata;

    always_comb begin
        case (funct3_q[1:0])
            2'd0: begin
                st_strobe = 4'b0001 << addr_q[1:0];
                st_wdata  = {4{wdata_q[7:0]}};
            end
            2'd1: begin
                st_strobe = addr_q[1] ? 4'b1100 : 4'b0011;
                st_wdata  = {2{wdata_q[15:0]}};
            end
            default: begin
                st_strobe = 4'b1111;
                st_wdata  = wdata_q;
            end
        endcase
    end

    // Load extraction: shift the addressed byte lane down to bit 0 first.
    logic [DATA_W-1:0] ld_shift;
    logic [DATA_W-1:0] ld_ext;

    always_comb begin
        ld_shift = dmem_rdata >> {addr_q[1:0], 3'b000};
        case (funct3_q)
            3'd0:    ld_ext = {{24{ld_shift[7]}}, ld_shift[7:0]};
            3'd1:    ld_ext = {{16{ld_shift[15]}}, ld_shift[15:0]};
            3'd4:    ld_ext = {24'd0, ld_shift[7:0]};
            3'd5:    ld_ext = {16'd0, ld_shift[15:0]};
            default: ld_ext = dmem_rdata;
        endcase
    end

    always_comb begin
        state_d       = state_q;
        is_store_d    = is_store_q;
        funct3_d      = funct3_q;
        addr_d        = addr_q;
        wdata_d       = wdata_q;
        rd_d          = rd_q;
        resp_data_d   = resp_data_q;
        resp_rd_d     = resp_rd_q;
        fault_cause_d = fault_cause_q;
        fault_addr_d  = fault_addr_q;

        case (state_q)
            S_IDLE: begin
                if (req_valid) begin
                    is_store_d = is_store;
                    funct3_d   = funct3;
                    addr_d     = addr;
                    wdata_d    = wdata;
                    rd_d       = rd_in;
                    if (illegal_in || misaligned_in) begin
                        // Illegal takes precedence when both apply.
                        fault_cause_d = illegal_in;
                        fault_addr_d  = addr;
                        state_d       = S_FAULT;
                    end else begin
                        fault_addr_d  = '0;
                        state_d       = S_BUS;
                    end
                end
            end
            S_BUS: begin
                if (dmem_ack) begin
                    resp_data_d = is_store_q ? '0 : ld_ext;
                    resp_rd_d   = is_store_q ? 5'd0 : rd_q;
                    state_d     = S_RESP;
                end
            end
            S_RESP: begin
                // Writeback fields read as zero outside the response pulse.
                resp_data_d = '0;
                resp_rd_d   = 5'd0;
                state_d     = S_IDLE;
            end
            S_FAULT: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= S_IDLE;
            is_store_q    <= 1'b0;
            funct3_q      <= 3'd0;
            addr_q        <= '0;
            wdata_q       <= '0;
            rd_q          <= 5'd0;
            resp_data_q   <= '0;
            resp_rd_q     <= 5'd0;
            fault_cause_q <= 1'b0;
            fault_addr_q  <= '0;
        end else begin
            state_q       <= state_d;
            is_store_q    <= is_store_d;
            funct3_q      <= funct3_d;
            addr_q        <= addr_d;
            wdata_q       <= wdata_d;
            rd_q          <= rd_d;
            resp_data_q   <= resp_data_d;
            resp_rd_q     <= resp_rd_d;
            fault_cause_q <= fault_cause_d;
            fault_addr_q  <= fault_addr_d;
        end
    end

    // Bus outputs are driven only in BUS, so a reset drops them at once.
    logic in_bus;
    assign in_bus      = (state_q == S_BUS);
    assign req_ready   = (state_q == S_IDLE);
    assign busy        = (state_q != S_IDLE);
    assign dmem_req    = in_bus;
    assign dmem_wen    = in_bus && is_store_q;
    assign dmem_addr   = in_bus ? {addr_q[ADDR_W-1:2], 2'b00} : '0;
    assign dmem_wdata  = (in_bus && is_store_q) ? st_wdata : '0;
    assign dmem_strobe = in_bus ? (is_store_q ? st_strobe : 4'b1111) : 4'b0000;
    assign resp_valid  = (state_q == S_RESP);
    assign resp_data   = resp_data_q;
    assign resp_rd     = resp_rd_q;
    assign fault_valid = (state_q == S_FAULT);
    assign fault_cause = (state_q == S_FAULT) && fault_cause_q;
    assign fault_addr  = fault_addr_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit with a scoreboard queue of expected
// completions, a cycle-stepped bus responder and bounded waits on outputs.
module tb_load_store_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic        is_store;
    logic [2:0]  funct3;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [4:0]  rd_in;
    logic        dmem_req;
    logic        dmem_wen;
    logic [31:0] dmem_addr;
    logic [31:0] dmem_wdata;
    logic [3:0]  dmem_strobe;
    logic [31:0] dmem_rdata;
    logic        dmem_ack;
    logic        resp_valid;
    logic [31:0] resp_data;
    logic [4:0]  resp_rd;
    logic        fault_valid;
    logic        fault_cause;
    logic [31:0] fault_addr;
    logic        busy;

    always #5 clk = ~clk;

    load_store_unit #(.ADDR_W(32), .DATA_W(32)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready),
        .is_store(is_store), .funct3(funct3), .addr(addr), .wdata(wdata), .rd_in(rd_in),
        .dmem_req(dmem_req), .dmem_wen(dmem_wen), .dmem_addr(dmem_addr),
        .dmem_wdata(dmem_wdata), .dmem_strobe(dmem_strobe),
        .dmem_rdata(dmem_rdata), .dmem_ack(dmem_ack),
        .resp_valid(resp_valid), .resp_data(resp_data), .resp_rd(resp_rd),
        .fault_valid(fault_valid), .fault_cause(fault_cause), .fault_addr(fault_addr),
        .busy(busy)
    );

    typedef struct packed {
        logic        fault;
        logic        cause;
        logic [31:0] data;    // resp_data, or fault_addr for a fault
        logic [4:0]  rd;
        logic        wen;
        logic [3:0]  strobe;
        logic [31:0] wdat;
        logic [31:0] daddr;
    } exp_t;

    exp_t sb_q[$];
    int   checks   = 0;
    int   failures = 0;

    function automatic exp_t mk_bus(input logic [31:0] data, input logic [4:0] rd,
                                    input logic wen, input logic [3:0] strobe,
                                    input logic [31:0] wdat, input logic [31:0] daddr);
        exp_t e;
        e.fault = 1'b0; e.cause = 1'b0; e.data = data; e.rd = rd;
        e.wen = wen; e.strobe = strobe; e.wdat = wdat; e.daddr = daddr;
        return e;
    endfunction

    function automatic exp_t mk_fault(input logic cause, input logic [31:0] faddr);
        exp_t e;
        e = '0;
        e.fault = 1'b1; e.cause = cause; e.data = faddr;
        return e;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drive one op in IDLE, service the bus with 'waits' wait cycles, then
    // pop the scoreboard when the DUT reports completion or fault.
    task automatic run_op(input logic st, input logic [2:0] f3, input logic [31:0] a,
                          input logic [31:0] wd, input logic [4:0] rd,
                          input logic [31:0] rdata, input int waits, input exp_t ex);
        exp_t e;
        int   req_cycles;
        int   lat;
        bit   seen;
        chk("ready_before_accept", {31'd0, req_ready}, 32'd1);
        req_valid = 1'b1; is_store = st; funct3 = f3; addr = a; wdata = wd; rd_in = rd;
        sb_q.push_back(ex);
        tick();
        // Scramble operands: the DUT must use its registered copies.
        req_valid = 1'b0; addr = 32'hFFFF_FFFF; wdata = 32'h5555_AAAA; funct3 = 3'd7; rd_in = 5'd31;
        if (!ex.fault) begin
            chk("bus_wen",    {31'd0, dmem_wen}, {31'd0, ex.wen});
            chk("bus_addr",   dmem_addr, ex.daddr);
            chk("bus_strobe", {28'd0, dmem_strobe}, {28'd0, ex.strobe});
            if (ex.wen) chk("bus_wdata", dmem_wdata, ex.wdat);
            req_cycles = 0;
            for (int i = 0; i <= waits; i++) begin
                if (dmem_req) req_cycles++;
                chk("busy_in_bus", {31'd0, busy}, 32'd1);
                if (i == waits) begin
                    dmem_ack = 1'b1; dmem_rdata = rdata;
                end
                tick();
                dmem_ack = 1'b0; dmem_rdata = 32'hDEAD_0000;
            end
            chk("req_held_cycles", req_cycles, waits + 1);
        end else begin
            chk("fault_no_req", {31'd0, dmem_req}, 32'd0);
        end
        lat  = 0;
        seen = 1'b0;
        while (!seen && lat < 4) begin
            if (resp_valid || fault_valid) seen = 1'b1;
            else begin
                tick();
                lat++;
            end
        end
        chk("out_seen", {31'd0, seen}, 32'd1);
        chk("out_latency", lat, 0);
        if (seen) begin
            e = sb_q.pop_front();
            chk("fault_valid", {31'd0, fault_valid}, {31'd0, e.fault});
            chk("resp_valid",  {31'd0, resp_valid},  {31'd0, ~e.fault});
            if (e.fault) begin
                chk("fault_cause", {31'd0, fault_cause}, {31'd0, e.cause});
                chk("fault_addr",  fault_addr, e.data);
            end else begin
                chk("resp_data", resp_data, e.data);
                chk("resp_rd",   {27'd0, resp_rd}, {27'd0, e.rd});
                chk("bus_dropped", {31'd0, dmem_req}, 32'd0);
            end
        end
        tick();
        chk("ready_after",      {31'd0, req_ready}, 32'd1);
        chk("idle_resp_valid",  {31'd0, resp_valid}, 32'd0);
        chk("idle_fault_valid", {31'd0, fault_valid}, 32'd0);
        chk("idle_resp_data",   resp_data, 32'd0);
        chk("idle_busy",        {31'd0, busy}, 32'd0);
        if (ex.fault) chk("fault_addr_held", fault_addr, ex.data);
    endtask

    initial begin
        rst = 1'b1; req_valid = 1'b0; is_store = 1'b0; funct3 = 3'd0;
        addr = 32'd0; wdata = 32'd0; rd_in = 5'd0; dmem_rdata = 32'd0; dmem_ack = 1'b0;
        tick();
        tick();
        // Reset state.
        chk("rst_ready",       {31'd0, req_ready}, 32'd1);
        chk("rst_req",         {31'd0, dmem_req}, 32'd0);
        chk("rst_resp_valid",  {31'd0, resp_valid}, 32'd0);
        chk("rst_fault_valid", {31'd0, fault_valid}, 32'd0);
        chk("rst_busy",        {31'd0, busy}, 32'd0);
        chk("rst_fault_addr",  fault_addr, 32'd0);
        chk("rst_resp_data",   resp_data, 32'd0);
        rst = 1'b0;
        tick();

        // LB sign-extended from top lane, zero-wait bus.
        run_op(1'b0, 3'd0, 32'h0000_1003, 32'd0, 5'd5, 32'h80FF_1234, 0,
               mk_bus(32'hFFFF_FF80, 5'd5, 1'b0, 4'b1111, 32'd0, 32'h0000_1000));
        // LHU upper half, four wait cycles.
        run_op(1'b0, 3'd5, 32'h0000_2002, 32'd0, 5'd9, 32'hBEEF_0000, 4,
               mk_bus(32'h0000_BEEF, 5'd9, 1'b0, 4'b1111, 32'd0, 32'h0000_2000));
        // SB to lane 1.
        run_op(1'b1, 3'd0, 32'h0000_0001, 32'h1234_56AB, 5'd7, 32'd0, 0,
               mk_bus(32'd0, 5'd0, 1'b1, 4'b0010, 32'hABAB_ABAB, 32'h0000_0000));
        // SH to upper half.
        run_op(1'b1, 3'd1, 32'h0000_0006, 32'h0000_CAFE, 5'd3, 32'd0, 1,
               mk_bus(32'd0, 5'd0, 1'b1, 4'b1100, 32'hCAFE_CAFE, 32'h0000_0004));
        // SW, full word.
        run_op(1'b1, 3'd2, 32'h0000_0010, 32'hDEAD_BEEF, 5'd1, 32'd0, 2,
               mk_bus(32'd0, 5'd0, 1'b1, 4'b1111, 32'hDEAD_BEEF, 32'h0000_0010));
        // LH sign-extended lower half.
        run_op(1'b0, 3'd1, 32'h0000_0020, 32'd0, 5'd12, 32'h1234_8001, 0,
               mk_bus(32'hFFFF_8001, 5'd12, 1'b0, 4'b1111, 32'd0, 32'h0000_0020));
        // LBU from lane 2.
        run_op(1'b0, 3'd4, 32'h0000_0032, 32'd0, 5'd20, 32'h00C3_0000, 0,
               mk_bus(32'h0000_00C3, 5'd20, 1'b0, 4'b1111, 32'd0, 32'h0000_0030));
        // LW aligned, word returned unchanged.
        run_op(1'b0, 3'd2, 32'h0000_0044, 32'd0, 5'd31, 32'h8765_4321, 3,
               mk_bus(32'h8765_4321, 5'd31, 1'b0, 4'b1111, 32'd0, 32'h0000_0044));
        // Faults: misaligned word, illegal store, illegal+misaligned store, misaligned half.
        run_op(1'b0, 3'd2, 32'h0000_0102, 32'd0, 5'd4, 32'd0, 0, mk_fault(1'b0, 32'h0000_0102));
        run_op(1'b1, 3'd4, 32'h0000_0200, 32'h1111_1111, 5'd4, 32'd0, 0, mk_fault(1'b1, 32'h0000_0200));
        run_op(1'b1, 3'd5, 32'h0000_0301, 32'd0, 5'd4, 32'd0, 0, mk_fault(1'b1, 32'h0000_0301));
        run_op(1'b0, 3'd1, 32'h0000_0405, 32'd0, 5'd4, 32'd0, 0, mk_fault(1'b0, 32'h0000_0405));
        run_op(1'b0, 3'd6, 32'h0000_0500, 32'd0, 5'd4, 32'd0, 0, mk_fault(1'b1, 32'h0000_0500));

        // Reset in cycle 2 of a waiting LW: bus drops, no completion appears.
        req_valid = 1'b1; is_store = 1'b0; funct3 = 3'd2; addr = 32'h0000_0040; rd_in = 5'd6;
        tick();
        req_valid = 1'b0;
        chk("rstmid_req_c1", {31'd0, dmem_req}, 32'd1);
        tick();
        rst = 1'b1;
        #1;
        chk("rstmid_req_drop", {31'd0, dmem_req}, 32'd0);
        chk("rstmid_ready",    {31'd0, req_ready}, 32'd1);
        tick();
        rst = 1'b0;
        dmem_ack = 1'b1; dmem_rdata = 32'h1234_5678;
        for (int i = 0; i < 3; i++) begin
            tick();
            dmem_ack = 1'b0;
            chk("rstmid_no_resp",  {31'd0, resp_valid}, 32'd0);
            chk("rstmid_no_fault", {31'd0, fault_valid}, 32'd0);
            chk("rstmid_no_req",   {31'd0, dmem_req}, 32'd0);
        end
        chk("rstmid_ready_after", {31'd0, req_ready}, 32'd1);
        chk("scoreboard_empty", sb_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Absolute bound on run time.
    initial begin
        #200000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
